// File: rtl/bsg_circular_pkg.sv
// Shared width helpers and status bundle for the circular-buffer trackers.
package bsg_circular_pkg;

    // Widest pointer / count carried in the shared status bundle.
    localparam int unsigned StatusPtrWidth = 16;
    localparam int unsigned StatusCntWidth = 17;

    // Pointer width; a single-slot buffer still gets a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Count width: must hold the value slots itself.
    function automatic int unsigned cnt_width(input int unsigned slots);
        return $clog2(slots + 1);
    endfunction

    // Read/write-side tracker status, zero-extended into fixed-width fields.
    typedef struct packed {
        logic [StatusPtrWidth-1:0] rd_ptr;
        logic [StatusPtrWidth-1:0] wr_ptr;
        logic [StatusCntWidth-1:0] count;
    } circ_status_t;

endpackage

// File: rtl/bsg_circular_ptr_async.sv
// Modulo-slots_p pointer register with asynchronous active-low reset.
module bsg_circular_ptr_async
    import bsg_circular_pkg::*;
#(
    parameter int unsigned slots_p   = 8,
    parameter int unsigned max_inc_p = 1,
    localparam int unsigned ptr_width_lp = ptr_width(slots_p),
    localparam int unsigned inc_width_lp = $clog2(max_inc_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic [inc_width_lp-1:0] inc_i,
    output logic [ptr_width_lp-1:0] o
);

    localparam int unsigned sum_width_lp = ptr_width_lp + 1;
    localparam bit          is_pow2_lp   = ((slots_p & (slots_p - 1)) == 0);

    logic [ptr_width_lp-1:0] ptr_q, ptr_d;

    if (slots_p == 1) begin : g_single
        // Only one slot: the pointer can never move.
        always_comb begin
            ptr_d = '0;
        end
    end else if (is_pow2_lp) begin : g_pow2
        // Power-of-two depth: wrap falls out of truncation.
        always_comb begin
            ptr_d = ptr_q + ptr_width_lp'(inc_i);
        end
    end else begin : g_mod
        logic [sum_width_lp-1:0] sum;
        logic [sum_width_lp-1:0] diff;
        // Non-power-of-two: pick ptr+inc-slots whenever that is non-negative.
        always_comb begin
            sum   = sum_width_lp'(ptr_q) + sum_width_lp'(inc_i);
            diff  = sum - sum_width_lp'(slots_p);
            ptr_d = diff[ptr_width_lp] ? sum[ptr_width_lp-1:0] : diff[ptr_width_lp-1:0];
        end
    end

    // Pointer state register.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o = ptr_q;

endmodule

// File: rtl/bsg_circular_rd_tracker.sv
// Read-end occupancy/pointer tracker for a circular buffer of slots_p entries.
module bsg_circular_rd_tracker
    import bsg_circular_pkg::*;
#(
    parameter int unsigned slots_p   = 8,
    parameter int unsigned max_add_p = 1,
    parameter int unsigned max_pop_p = 1,
    localparam int unsigned ptr_width_lp = ptr_width(slots_p),
    localparam int unsigned cnt_width_lp = cnt_width(slots_p),
    localparam int unsigned add_width_lp = $clog2(max_add_p + 1),
    localparam int unsigned pop_width_lp = $clog2(max_pop_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic [add_width_lp-1:0] wr_add_i,
    input  logic [pop_width_lp-1:0] pop_req_i,
    output logic [pop_width_lp-1:0] pop_ack_o,
    output logic [ptr_width_lp-1:0] rd_ptr_o,
    output logic [ptr_width_lp-1:0] wr_ptr_o,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    overflow_o
);

    localparam int unsigned sum_width_lp = cnt_width_lp + 1;
    localparam int unsigned cmp_width_lp =
        (pop_width_lp > cnt_width_lp) ? pop_width_lp : cnt_width_lp;

    if (slots_p < 1 || max_pop_p > slots_p || max_add_p > slots_p) begin : g_bad_params
        $error("bsg_circular_rd_tracker: need slots_p>=1 and max_add_p, max_pop_p <= slots_p");
    end

    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [pop_width_lp-1:0] pop_ack;
    logic [add_width_lp-1:0] wr_inc;
    logic [sum_width_lp-1:0] sum;

    // Grant min(pop_req, count); same-cycle writes are not yet poppable.
    always_comb begin
        pop_ack = pop_req_i;
        if (cmp_width_lp'(pop_req_i) > cmp_width_lp'(count_q)) begin
            pop_ack = pop_width_lp'(count_q);
        end
    end

    // Next count, clamped at capacity; a clamped write only advances wr_ptr into free space.
    always_comb begin
        sum        = sum_width_lp'(count_q) + sum_width_lp'(wr_add_i) - sum_width_lp'(pop_ack);
        count_d    = cnt_width_lp'(sum);
        overflow_d = overflow_q;
        wr_inc     = wr_add_i;
        if (sum > sum_width_lp'(slots_p)) begin
            count_d    = cnt_width_lp'(slots_p);
            overflow_d = 1'b1;
            wr_inc     = add_width_lp'(sum_width_lp'(slots_p) - sum_width_lp'(count_q)
                                       + sum_width_lp'(pop_ack));
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    bsg_circular_ptr_async #(
        .slots_p   (slots_p),
        .max_inc_p (max_pop_p)
    ) u_rd_ptr (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .inc_i     (pop_ack),
        .o         (rd_ptr_o)
    );

    bsg_circular_ptr_async #(
        .slots_p   (slots_p),
        .max_inc_p (max_add_p)
    ) u_wr_ptr (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .inc_i     (wr_inc),
        .o         (wr_ptr_o)
    );

    assign pop_ack_o  = pop_ack;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == cnt_width_lp'(slots_p));

`ifndef SYNTHESIS
    logic [sum_width_lp-1:0] ptr_diff;

    // Pointer distance modulo slots_p, used only by the consistency check.
    always_comb begin
        if (wr_ptr_o >= rd_ptr_o) begin
            ptr_diff = sum_width_lp'(wr_ptr_o) - sum_width_lp'(rd_ptr_o);
        end else begin
            ptr_diff = sum_width_lp'(wr_ptr_o) + sum_width_lp'(slots_p) - sum_width_lp'(rd_ptr_o);
        end
    end

    a_ptr_count_consistent: assert property (@(posedge clk) disable iff (!reset_n_i)
        (count_q == cnt_width_lp'(slots_p)) ? (rd_ptr_o == wr_ptr_o)
                                            : (sum_width_lp'(count_q) == ptr_diff));
`endif

endmodule

// File: tb/tb_bsg_circular_rd_tracker.sv
// Directed-vector bench for bsg_circular_rd_tracker with slots_p=5.
module tb_bsg_circular_rd_tracker;

    localparam int unsigned Slots  = 5;
    localparam int unsigned MaxAdd = 2;
    localparam int unsigned MaxPop = 3;

    logic       clk;
    logic       reset_n_i;
    logic [1:0] wr_add_i;
    logic [1:0] pop_req_i;
    logic [1:0] pop_ack_o;
    logic [2:0] rd_ptr_o;
    logic [2:0] wr_ptr_o;
    logic [2:0] count_o;
    logic       empty_o;
    logic       full_o;
    logic       overflow_o;

    // {rd_ptr, wr_ptr, count, empty, full, overflow}
    logic [11:0] st;
    assign st = {rd_ptr_o, wr_ptr_o, count_o, empty_o, full_o, overflow_o};

    int checks = 0;
    int passes = 0;

    bsg_circular_rd_tracker #(
        .slots_p   (Slots),
        .max_add_p (MaxAdd),
        .max_pop_p (MaxPop)
    ) dut (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .wr_add_i   (wr_add_i),
        .pop_req_i  (pop_req_i),
        .pop_ack_o  (pop_ack_o),
        .rd_ptr_o   (rd_ptr_o),
        .wr_ptr_o   (wr_ptr_o),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        wr_add_i  = 2'd0;
        pop_req_i = 2'd3;
        #1;
        checks++;
        if (pop_ack_o !== 2'd0) $display("FAIL reset_ack: got %0d want 0", pop_ack_o);
        else passes++;
        checks++;
        if (st !== {3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_state: got %b want %b", st, {3'd0, 3'd0, 3'd0, 3'b100});
        else passes++;
        tick();
        tick();
        @(negedge clk);
        reset_n_i = 1'b1;
        pop_req_i = 2'd0;
    endtask

    task automatic test_fill();
        logic [11:0] exp;
        wr_add_i  = 2'd1;
        pop_req_i = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp = {3'd0, 3'(i % 5), 3'(i), 1'b0, (i == 5), 1'b0};
            checks++;
            if (st !== exp) $display("FAIL fill_%0d: got %b want %b", i, st, exp);
            else passes++;
        end
    endtask

    task automatic test_wrap_pop();
        // Move to rd_ptr=3, count=5.
        wr_add_i  = 2'd2;
        pop_req_i = 2'd3;
        #1;
        checks++;
        if (pop_ack_o !== 2'd3) $display("FAIL setup_ack: got %0d want 3", pop_ack_o);
        else passes++;
        tick();
        wr_add_i  = 2'd1;
        pop_req_i = 2'd0;
        tick();
        checks++;
        if (st !== {3'd3, 3'd3, 3'd5, 3'b010})
            $display("FAIL setup_state: got %b want %b", st, {3'd3, 3'd3, 3'd5, 3'b010});
        else passes++;
        wr_add_i  = 2'd0;
        pop_req_i = 2'd3;
        #1;
        checks++;
        if (pop_ack_o !== 2'd3) $display("FAIL wrap_ack: got %0d want 3", pop_ack_o);
        else passes++;
        tick();
        checks++;
        if (st !== {3'd1, 3'd3, 3'd2, 3'b000})
            $display("FAIL wrap_state: got %b want %b", st, {3'd1, 3'd3, 3'd2, 3'b000});
        else passes++;
    endtask

    task automatic test_partial_grant();
        // count=2, request 3 with a same-cycle write.
        wr_add_i  = 2'd1;
        pop_req_i = 2'd3;
        #1;
        checks++;
        if (pop_ack_o !== 2'd2) $display("FAIL partial_ack_wr: got %0d want 2", pop_ack_o);
        else passes++;
        tick();
        checks++;
        if (st !== {3'd3, 3'd4, 3'd1, 3'b000})
            $display("FAIL partial_state_wr: got %b want %b", st, {3'd3, 3'd4, 3'd1, 3'b000});
        else passes++;
        // Drain the last entry.
        wr_add_i = 2'd0;
        #1;
        checks++;
        if (pop_ack_o !== 2'd1) $display("FAIL partial_ack: got %0d want 1", pop_ack_o);
        else passes++;
        tick();
        checks++;
        if (st !== {3'd4, 3'd4, 3'd0, 3'b100})
            $display("FAIL drain_state: got %b want %b", st, {3'd4, 3'd4, 3'd0, 3'b100});
        else passes++;
        // Empty with add and pop: nothing granted.
        wr_add_i  = 2'd2;
        pop_req_i = 2'd2;
        #1;
        checks++;
        if (pop_ack_o !== 2'd0) $display("FAIL empty_ack: got %0d want 0", pop_ack_o);
        else passes++;
        tick();
        checks++;
        if (st !== {3'd4, 3'd1, 3'd2, 3'b000})
            $display("FAIL empty_add_state: got %b want %b", st, {3'd4, 3'd1, 3'd2, 3'b000});
        else passes++;
    endtask

    task automatic test_full_add_pop();
        wr_add_i  = 2'd2;
        pop_req_i = 2'd0;
        tick();
        wr_add_i = 2'd1;
        tick();
        checks++;
        if (st !== {3'd4, 3'd4, 3'd5, 3'b010})
            $display("FAIL refill_state: got %b want %b", st, {3'd4, 3'd4, 3'd5, 3'b010});
        else passes++;
        wr_add_i  = 2'd1;
        pop_req_i = 2'd1;
        #1;
        checks++;
        if (pop_ack_o !== 2'd1) $display("FAIL full_ack: got %0d want 1", pop_ack_o);
        else passes++;
        tick();
        checks++;
        if (st !== {3'd0, 3'd0, 3'd5, 3'b010})
            $display("FAIL full_add_pop_state: got %b want %b", st, {3'd0, 3'd0, 3'd5, 3'b010});
        else passes++;
    endtask

    task automatic test_overflow();
        wr_add_i  = 2'd1;
        pop_req_i = 2'd0;
        tick();
        checks++;
        if (st !== {3'd0, 3'd0, 3'd5, 3'b011})
            $display("FAIL overflow_state: got %b want %b", st, {3'd0, 3'd0, 3'd5, 3'b011});
        else passes++;
        // Clamped write: only the one freed slot is consumed.
        wr_add_i  = 2'd2;
        pop_req_i = 2'd1;
        tick();
        checks++;
        if (st !== {3'd1, 3'd1, 3'd5, 3'b011})
            $display("FAIL clamp_state: got %b want %b", st, {3'd1, 3'd1, 3'd5, 3'b011});
        else passes++;
        wr_add_i  = 2'd0;
        pop_req_i = 2'd3;
        tick();
        checks++;
        if (st !== {3'd4, 3'd1, 3'd2, 3'b001})
            $display("FAIL sticky_state: got %b want %b", st, {3'd4, 3'd1, 3'd2, 3'b001});
        else passes++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        reset_n_i = 1'b0;
        pop_req_i = 2'd3;
        wr_add_i  = 2'd1;
        #1;
        checks++;
        if (st !== {3'd0, 3'd0, 3'd0, 3'b100})
            $display("FAIL async_reset_state: got %b want %b", st, {3'd0, 3'd0, 3'd0, 3'b100});
        else passes++;
        checks++;
        if (pop_ack_o !== 2'd0) $display("FAIL async_reset_ack: got %0d want 0", pop_ack_o);
        else passes++;
        @(negedge clk);
        reset_n_i = 1'b1;
        pop_req_i = 2'd0;
        wr_add_i  = 2'd1;
        tick();
        checks++;
        if (st !== {3'd0, 3'd1, 3'd1, 3'b000})
            $display("FAIL post_reset_write: got %b want %b", st, {3'd0, 3'd1, 3'd1, 3'b000});
        else passes++;
        // Entry written last cycle is poppable now.
        wr_add_i  = 2'd0;
        pop_req_i = 2'd1;
        #1;
        checks++;
        if (pop_ack_o !== 2'd1) $display("FAIL latency_ack: got %0d want 1", pop_ack_o);
        else passes++;
        tick();
        checks++;
        if (st !== {3'd1, 3'd1, 3'd0, 3'b100})
            $display("FAIL latency_state: got %b want %b", st, {3'd1, 3'd1, 3'd0, 3'b100});
        else passes++;
    endtask

    initial begin
        reset_n_i = 1'b1;
        wr_add_i  = 2'd0;
        pop_req_i = 2'd0;
        #1;
        test_reset();
        test_fill();
        test_wrap_pop();
        test_partial_grant();
        test_full_add_pop();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bsg_circular_rd_tracker.md
Name: bsg_circular_rd_tracker

Overview:
- Read-side occupancy and pointer tracker for a circular buffer of slots_p entries.
- Tracks the write pointer and occupancy from the producer's per-cycle add count.
- Grants consumer pop requests of up to max_pop_p entries per cycle, limited to what is resident.
- Exports read/write pointers, count, empty/full and a sticky overflow flag; sits beside the buffer RAM as its read-end controller.

Parameters:
- slots_p, 8, number of buffer slots (>=1, any value, not only powers of two).
- max_add_p, 1, max entries the producer adds per cycle.
- max_pop_p, 1, max entries the consumer may pop per cycle.
- ptr_width_lp (local), `BSG_SAFE_CLOG2(slots_p), pointer width.
- cnt_width_lp (local), $clog2(slots_p+1), count width.

Ports:
- clk  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- wr_add_i  in  $clog2(max_add_p+1)  entries written this cycle.
- pop_req_i  in  $clog2(max_pop_p+1)  entries the consumer wants to pop.
- pop_ack_o  out  $clog2(max_pop_p+1)  entries granted this cycle.
- rd_ptr_o  out  ptr_width_lp  slot index of oldest entry.
- wr_ptr_o  out  ptr_width_lp  slot index of next write.
- count_o  out  cnt_width_lp  resident entries.
- empty_o  out  1  count_o==0.
- full_o  out  1  count_o==slots_p.
- overflow_o  out  1  sticky: a write exceeded capacity.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n_i low, takes effect immediately, independent of clk): rd_ptr=0, wr_ptr=0, count=0, overflow=0. Combinationally, empty_o=1, full_o=0 and pop_ack_o=0.
- Deassertion is assumed synchronized upstream. The first active edge after release updates state normally.
- pop_ack_o = min(pop_req_i, count_r). It is purely combinational from pop_req_i and registered count, and never depends on same-cycle wr_add_i.
- Written entries become poppable the cycle after the write (1-cycle write-to-read latency).
- Next count: sum = count_r + wr_add_i - pop_ack_o, computed at cnt_width_lp+1 bits.
  - If sum > slots_p: count_n = slots_p, overflow_n = 1, and wr_ptr advances only by (slots_p - count_r + pop_ack_o), so it never passes rd_ptr.
  - Otherwise count_n = sum.
- overflow_o stays at 1 until reset.
- Pointer advance: ptr_n = (ptr_r + inc) mod slots_p.
  - rd_ptr uses inc = pop_ack_o; wr_ptr uses the clamped write increment.
  - Power-of-2 slots_p: natural truncation.
  - Otherwise: compute ptr_r + inc - slots_p at ptr_width_lp+1 bits in parallel with ptr_r + inc, and select the wrapped value when the difference is non-negative.
  - inc never exceeds slots_p. Elaborate-time error if max_pop_p > slots_p or max_add_p > slots_p.
- slots_p==1: pointers tied to 0; count is 0/1.
- Simultaneous add and pop when full: legal. The pop frees space in the same cycle, so count holds and there is no overflow.
- Simultaneous add and pop when empty: pop_ack_o=0 and count becomes wr_add_i.
- Invariant, asserted in simulation: count_r == (wr_ptr_r - rd_ptr_r) mod slots_p, except that when count_r==slots_p the pointers are equal. Tag the assertion so synthesis drops it.
- Outputs rd_ptr_o, wr_ptr_o, count_o and overflow_o come directly from flops. empty_o and full_o are compares on count_r.

Decomposition:
- Shared package bsg_circular_pkg holds:
  - width helper constants (ptr/count width functions of slots);
  - a typedef for the {rd_ptr, wr_ptr, count} status bundle, reused by the matching write-side tracker.
- One natural sub-module: bsg_circular_ptr_async.
  - Parameters slots_p and max_inc_p; inputs clk, reset_n_i, inc_i; output o.
  - Contains the modulo-wrap flop and logic with asynchronous active-low reset.
  - Instantiated twice, once per pointer.
  - Count, clamp and grant logic live in the top module.

Test Plan:
- Reset: slots_p=5, max_pop_p=3, pop_req_i=3 with reset_n_i low -> pop_ack_o=0, rd/wr_ptr=0, count=0, empty=1, full=0. Drop reset_n_i mid-cycle after activity -> all state zero before the next edge.
- Fill: wr_add_i=1 for 5 cycles, no pops -> count 1..5, full_o=1 after the 5th edge, wr_ptr back to 0, overflow_o=0.
- Wrap pop: state rd_ptr=3, count=5, pop_req_i=3 -> pop_ack_o=3, next rd_ptr=1, count=2.
- Partial grant: count=2, pop_req_i=3 -> pop_ack_o=2, next count=0, empty_o=1. Same-cycle wr_add_i=1 -> count=1 and pop_ack_o still 2.
- Full with simultaneous add and pop: count=5, wr_add_i=1, pop_req_i=1 -> pop_ack_o=1, count stays 5, both pointers advance by 1, overflow_o=0.
- Overflow: count=5, wr_add_i=1, pop_req_i=0 -> count stays 5, wr_ptr unchanged, overflow_o=1 and stays 1 until reset.
